// File: rtl/cmult_pkg.sv
// cmult_pipe shared package: width defaults, packed-complex slice indices
// and the generic saturation helper.
package cmult_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int OUT_W_DEF  = 32;

  // Working width of the saturation helper; callers sign-extend into it.
  localparam int CLIP_W = 128;

  // Slice index of each half of a packed {real, imag} word.
  localparam int CPLX_RE = 1;
  localparam int CPLX_IM = 0;

  // Returns {over, under} for a signed value against a w-bit signed range.
  function automatic logic [1:0] sat_clip(
    input logic signed [CLIP_W-1:0] v,
    input int                       w
  );
    logic signed [CLIP_W-1:0] one;
    logic signed [CLIP_W-1:0] hi;
    logic signed [CLIP_W-1:0] lo;
    one    = '0;
    one[0] = 1'b1;
    hi     = (one <<< (w - 1)) - one;
    lo     = ~hi;
    return {v > hi, v < lo};
  endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// One complex component: optional round (CMULT_ROUND_EN), arithmetic
// shift by SHIFT, then saturation to OUT_W bits.
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int IN_W  = 34,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0] full_i,
  output logic [OUT_W-1:0]       val_o,
  output logic                   sat_o
);

  // One guard bit so the rounding increment cannot wrap.
  localparam int EW = IN_W + 1;

  logic signed [EW-1:0]     wide;
  logic signed [EW-1:0]     biased;
  logic signed [EW-1:0]     scaled;
  logic signed [CLIP_W-1:0] ext;
  logic [1:0]               clip;

  assign wide = {full_i[IN_W-1], full_i};

`ifdef CMULT_ROUND_EN
  if (SHIFT > 0) begin : g_rnd
    localparam logic [EW-1:0] HALF = EW'(1) << (SHIFT - 1);
    assign biased = wide + $signed(HALF);
  end else begin : g_nornd
    assign biased = wide;
  end
`else
  assign biased = wide;
`endif

  assign scaled = biased >>> SHIFT;
  assign ext    = {{(CLIP_W-EW){scaled[EW-1]}}, scaled};
  assign clip   = sat_clip(ext, OUT_W);
  assign sat_o  = |clip;

  // Clamp to the nearest representable bound on overflow.
  always_comb begin
    val_o = ext[OUT_W-1:0];
    if (clip[1]) begin
      val_o = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (clip[0]) begin
      val_o = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/cmult_pipe.sv
// Three-stage complex multiplier with global stall, flush and conjugate.
// Optional rounding before the shift is enabled by CMULT_ROUND_EN.
module cmult_pipe
  import cmult_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SHIFT  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] a,
  input  logic [2*DATA_W-1:0] b,
  input  logic                conj_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*OUT_W-1:0]  c,
  output logic                sat
);

  localparam int PW = 2*DATA_W + 1;
  localparam int FW = 2*DATA_W + 2;

  logic                     v1_q, v2_q, v3_q;
  logic                     advance, accept;
  logic signed [DATA_W-1:0] ar_q, ai_q, br_q, bi_q;
  logic                     cj_q;
  logic signed [DATA_W:0]   bin, bip;
  logic signed [PW-1:0]     rr_d, ii_d, ri_d, ir_d;
  logic signed [PW-1:0]     rr_q, ii_q, ri_q, ir_q;
  logic signed [FW-1:0]     cr_d, ci_d;
  logic [OUT_W-1:0]         re_d, im_d;
  logic                     sre_d, sim_d;
  logic [2*OUT_W-1:0]       c_d, c_q;
  logic                     sat_d, sat_q;

  assign advance  = !v3_q | out_ready;
  assign in_ready = advance & !flush;
  assign accept   = in_valid & in_ready;

  assign bin  = {bi_q[DATA_W-1], bi_q};
  assign bip  = cj_q ? -bin : bin;
  assign rr_d = PW'(ar_q) * PW'(br_q);
  assign ii_d = PW'(ai_q) * PW'(bip);
  assign ri_d = PW'(ar_q) * PW'(bip);
  assign ir_d = PW'(ai_q) * PW'(br_q);

  assign cr_d = FW'(rr_q) - FW'(ii_q);
  assign ci_d = FW'(ri_q) + FW'(ir_q);

  cmult_round_sat #(
    .IN_W  (FW),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_re (
    .full_i (cr_d),
    .val_o  (re_d),
    .sat_o  (sre_d)
  );

  cmult_round_sat #(
    .IN_W  (FW),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_im (
    .full_i (ci_d),
    .val_o  (im_d),
    .sat_o  (sim_d)
  );

  assign c_d   = {re_d, im_d};
  assign sat_d = sre_d | sim_d;

  // Stage valids: flush clears all, otherwise shift on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (advance) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // S1 operand capture on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q <= '0;
      ai_q <= '0;
      br_q <= '0;
      bi_q <= '0;
      cj_q <= 1'b0;
    end else if (accept) begin
      ar_q <= a[CPLX_RE*DATA_W +: DATA_W];
      ai_q <= a[CPLX_IM*DATA_W +: DATA_W];
      br_q <= b[CPLX_RE*DATA_W +: DATA_W];
      bi_q <= b[CPLX_IM*DATA_W +: DATA_W];
      cj_q <= conj_b;
    end
  end

  // S2 partial products; data only moves with a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      ii_q <= '0;
      ri_q <= '0;
      ir_q <= '0;
    end else if (advance && v1_q) begin
      rr_q <= rr_d;
      ii_q <= ii_d;
      ri_q <= ri_d;
      ir_q <= ir_d;
    end
  end

  // S3 scaled, saturated result held while back-pressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= '0;
      sat_q <= 1'b0;
    end else if (advance && v2_q) begin
      c_q   <= c_d;
      sat_q <= sat_d;
    end
  end

  assign out_valid = v3_q;
  assign c         = c_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_cmult_pipe.sv
// Scoreboard bench for cmult_pipe: default build plus SHIFT=1 and
// SHIFT=15 instances; expectations honour CMULT_ROUND_EN.
module tb_cmult_pipe;

`ifdef CMULT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        in_valid, in_ready, conj_b;
  logic [31:0] a, b;
  logic        out_valid, out_ready, sat;
  logic [63:0] c;

  logic        iv1, ir1, ov1, s1;
  logic [31:0] a1, b1;
  logic [63:0] c1;
  logic        iv2, ir2, ov2, s2;
  logic [31:0] a2, b2;
  logic [63:0] c2;
  logic        cj0 = 1'b0;
  logic        rdy1 = 1'b1;

  int          checks = 0;
  int          errors = 0;
  logic [64:0] q0[$];
  logic [64:0] q1[$];
  logic [64:0] q2[$];
  bit          bp_phase = 1'b0;

  always #5 clk = ~clk;

  cmult_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .conj_b(conj_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .sat(sat)
  );

  cmult_pipe #(.SHIFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .conj_b(cj0),
    .out_valid(ov1), .out_ready(rdy1),
    .c(c1), .sat(s1)
  );

  cmult_pipe #(.SHIFT(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv2), .in_ready(ir2),
    .a(a2), .b(b2), .conj_b(cj0),
    .out_valid(ov2), .out_ready(rdy1),
    .c(c2), .sat(s2)
  );

  function automatic logic [31:0] pk(input int re, input int im);
    logic [31:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction

  function automatic logic [64:0] ex(input int re, input int im, input bit s);
    return {s, re, im};
  endfunction

  task automatic chk(input string nm, input logic [64:0] got,
                     input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got c=(%0d,%0d) sat=%0b, want c=(%0d,%0d) sat=%0b",
               nm, $signed(got[63:32]), $signed(got[31:0]), got[64],
               $signed(exp[63:32]), $signed(exp[31:0]), exp[64]);
    end
  endtask

  task automatic chkb(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", nm, got, exp);
    end
  endtask

  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input bit cj, input bit push, input logic [64:0] e);
    int n;
    @(negedge clk);
    a = pk(ar, ai);
    b = pk(br, bi);
    conj_b = cj;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, want 1", n);
    end else if (push) begin
      q0.push_back(e);
    end
  endtask

  task automatic lat_check(input string nm);
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL %s: got latency %0d cycles, want 3", nm, n);
    end
  endtask

  // Output monitor for the default instance.
  always @(negedge clk) begin
    #2;
    if (rst_n && !flush && out_valid && out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got c=(%0d,%0d), want no output",
                 $signed(c[63:32]), $signed(c[31:0]));
      end else begin
        chk("result", {sat, c}, q0.pop_front());
      end
    end
    if (rst_n && out_valid && !out_ready) begin
      chkb("stall_in_ready", in_ready, 1'b0);
      if (bp_phase && q0.size() > 0) chk("stall_hold", {sat, c}, q0[0]);
    end
  end

  // Output monitors for the shifted instances.
  always @(negedge clk) begin
    #2;
    if (rst_n && !flush && ov1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_shift1: got extra output, want none");
      end else begin
        chk("shift1", {s1, c1}, q1.pop_front());
      end
    end
    if (rst_n && !flush && ov2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_shift15: got extra output, want none");
      end else begin
        chk("shift15", {s2, c2}, q2.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ar ai br bi cj | er ei es
  int tv [8][8] = '{
    '{1, 2, 3, 4, 0, -5, 10, 0},
    '{5, -1, 2, 3, 0, 13, 13, 0},
    '{-4, 7, 1, 1, 0, -11, 3, 0},
    '{100, 0, 0, 100, 0, 0, 10000, 0},
    '{2, 2, 2, -2, 0, 8, 0, 0},
    '{-10, -20, 3, -5, 0, -130, -10, 0},
    '{1000, 1000, 1000, 1000, 0, 0, 2000000, 0},
    '{7, 0, 0, -1, 1, 0, 7, 0}
  };

  initial begin
    int n;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    conj_b = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    iv1 = 1'b0;
    iv2 = 1'b0;
    a1 = '0;
    b1 = '0;
    a2 = '0;
    b2 = '0;
    repeat (2) @(negedge clk);
    #1;
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_c", {sat, c}, ex(0, 0, 0));
    chkb("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    send(32767, 32767, 32767, 32767, 0, 1, ex(0, 2147352578, 0));
    lat_check("lat_max_pos");
    send(-32768, -32768, -32768, -32768, 0, 1, ex(0, 2147483647, 1));
    send(0, -32768, 0, -32768, 0, 1, ex(-1073741824, 0, 0));
    send(32767, 32767, 32767, 32767, 1, 1, ex(2147352578, 0, 0));
    send(-32768, -32768, -32768, -32768, 1, 1, ex(2147483647, 0, 1));
    @(negedge clk);
    in_valid = 1'b0;

    a1 = pk(3, 0);
    b1 = pk(1, 0);
    iv1 = 1'b1;
    q1.push_back(ex(RND ? 2 : 1, 0, 0));
    a2 = pk(16384, 0);
    b2 = pk(16384, 0);
    iv2 = 1'b1;
    q2.push_back(ex(8192, 0, 0));
    #1;
    chkb("shift1_in_ready", ir1, 1'b1);
    chkb("shift15_in_ready", ir2, 1'b1);
    @(negedge clk);
    a1 = pk(-3, 0);
    q1.push_back(ex(RND ? -1 : -2, 0, 0));
    iv2 = 1'b0;
    @(negedge clk);
    iv1 = 1'b0;
    repeat (6) @(negedge clk);

    bp_phase = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4] != 0, 1,
               ex(tv[i][5], tv[i][6], tv[i][7] != 0));
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    bp_phase = 1'b0;
    chkb("bp_drained", q0.size() == 0, 1'b1);

    @(negedge clk);
    out_ready = 1'b0;
    send(1, 1, 1, 1, 0, 0, '0);
    send(2, 2, 2, 2, 0, 0, '0);
    send(3, 3, 3, 3, 0, 0, '0);
    @(negedge clk);
    flush = 1'b1;
    a = pk(9, 9);
    b = pk(1, 1);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chkb("flush_in_ready", in_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (5) begin
      #1;
      chkb("flush_no_out", out_valid, 1'b0);
      @(negedge clk);
    end
    send(1, 2, 3, 4, 0, 1, ex(-5, 10, 0));
    lat_check("lat_after_flush");
    repeat (4) @(negedge clk);

    out_ready = 1'b0;
    send(4, 4, 4, 4, 0, 0, '0);
    send(5, 5, 5, 5, 0, 0, '0);
    send(6, 6, 6, 6, 0, 0, '0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chkb("pre_rst_valid", out_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chkb("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_c", {sat, c}, ex(0, 0, 0));
    chkb("mid_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(5, -1, 2, 3, 0, 1, ex(13, 13, 0));
    lat_check("lat_after_reset");

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d/%0d pending, want 0/0/0",
               q0.size(), q1.size(), q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
